// File: rtl/gps_pkg.sv
// Shared types and constants for the GPS NMEA front end: FSM state and
// error-code enums, ASCII framing characters, line buffer geometry and
// hex-digit helpers.
package gps_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_BODY    = 3'd1,
        ST_CSUM_HI = 3'd2,
        ST_CSUM_LO = 3'd3,
        ST_WAIT_CR = 3'd4,
        ST_WAIT_LF = 3'd5,
        ST_REPLAY  = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        ERR_OVERFLOW = 2'd0,
        ERR_FORMAT   = 2'd1,
        ERR_CHECKSUM = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } err_code_t;

    localparam logic [7:0] ASCII_DOLLAR = 8'h24;
    localparam logic [7:0] ASCII_STAR   = 8'h2A;
    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_LF     = 8'h0A;

    localparam int BUF_DEPTH = 128;
    localparam int BUF_AW    = 7;

    // Uppercase hex digit only: '0'-'9' or 'A'-'F'.
    function automatic logic is_hex(input logic [7:0] c);
        return ((c >= 8'h30) && (c <= 8'h39)) || ((c >= 8'h41) && (c <= 8'h46));
    endfunction

    function automatic logic [3:0] hex_val(input logic [7:0] c);
        if (c <= 8'h39) return c[3:0];
        else            return c[3:0] + 4'd9;
    endfunction

endpackage

// File: rtl/nmea_line_buf.sv
// Sentence buffer: 128x8 simple dual-port RAM, one write port used by
// framing and one synchronous-read port used by replay. The read register
// holds its value while i_rd_en is low, so it doubles as the replay prefetch
// stage.
module nmea_line_buf
    import gps_pkg::*;
(
    input  logic              sclk,
    input  logic              i_wr_en,
    input  logic [BUF_AW-1:0] i_wr_addr,
    input  logic [7:0]        i_wr_data,
    input  logic              i_rd_en,
    input  logic [BUF_AW-1:0] i_rd_addr,
    output logic [7:0]        o_rd_data
);

    logic [7:0] r_mem [BUF_DEPTH];
    logic [7:0] r_rd_data;

    // Write port, driven by the framing side.
    always_ff @(posedge sclk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    end

    // Synchronous read with enable; data holds while the replay pipe stalls.
    always_ff @(posedge sclk) begin
        if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/nmea_frame_ctrl.sv
// NMEA sentence framer/verifier: frames '$'..CR LF, checks the *hh XOR
// checksum, buffers the sentence and replays verified sentences on a
// valid/ready stream. Dropped sentences pulse frameErr with a reason code.
// Optional build macro NMEA_GGA_FILTER_EN: only verified GGA sentences
// (any talker) are replayed; other verified sentences are silently dropped.
//
// state      | meaning
// -----------+--------------------------------------------------
// ST_IDLE    | hunting for '$'
// ST_BODY    | storing/XORing body bytes until '*'
// ST_CSUM_HI | expecting high checksum hex digit
// ST_CSUM_LO | expecting low checksum hex digit
// ST_WAIT_CR | expecting CR
// ST_WAIT_LF | expecting LF, checksum decided on this byte
// ST_REPLAY  | streaming '$'..last body byte to the parser
module nmea_frame_ctrl
    import gps_pkg::*;
#(
    parameter int SYSCLK_FREQ = 100_000_000,
    parameter int TIMEOUT_MS  = 10,
    parameter int MAX_LEN     = 82
)(
    input  logic        sclk,
    input  logic        rstn,
    input  logic [7:0]  rxByte,
    input  logic        rxValid,
    output logic [7:0]  frameByte,
    output logic        frameValid,
    input  logic        frameReady,
    output logic        frameStart,
    output logic        frameEnd,
    output logic        frameOk,
    output logic        frameErr,
    output logic [1:0]  errCode,
    output logic [15:0] goodCount,
    output logic [15:0] badCount
);

    localparam int unsigned TMO_LIMIT = SYSCLK_FREQ / 1000 * TIMEOUT_MS;
    localparam int TMO_W = $clog2(TMO_LIMIT + 1);
    localparam logic [TMO_W-1:0] TMO_RELOAD = TMO_W'(TMO_LIMIT - 1);
    localparam logic [7:0] LEN_MAX = 8'(MAX_LEN);

    state_t r_state, w_state_nx;

    logic [TMO_W-1:0] r_tmo;
    logic [7:0]  r_len, r_xor, r_csum;
    logic [6:0]  r_last;
    logic [7:0]  r_rd_ptr;
    logic        r_pf_vld, r_pf_start, r_pf_end;
    logic        r_out_vld, r_out_start, r_out_end;
    logic [7:0]  r_out_byte;
    logic        r_ok, r_err;
    logic [1:0]  r_err_code;
    logic [15:0] r_good, r_bad;

    logic        w_framing, w_is_dollar, w_gga_ok;
    logic [7:0]  w_len_nx;
    logic        w_wr_en, w_restart, w_err, w_ok, w_launch;
    logic [6:0]  w_wr_addr;
    err_code_t   w_err_code;
    logic        w_adv, w_rd_more, w_rd_en;
    logic [6:0]  w_rd_addr;
    logic [7:0]  w_rd_data;

    assign w_framing   = r_state inside {ST_BODY, ST_CSUM_HI, ST_CSUM_LO, ST_WAIT_CR, ST_WAIT_LF};
    assign w_is_dollar = (rxByte == ASCII_DOLLAR);
    assign w_len_nx    = r_len + 8'd1;

`ifdef NMEA_GGA_FILTER_EN
    logic [23:0] r_gga;
    assign w_gga_ok = (r_gga == 24'h474741);
`else
    assign w_gga_ok = 1'b1;
`endif

    // State register.
    always_ff @(posedge sclk) begin
        if (!rstn) r_state <= ST_IDLE;
        else       r_state <= w_state_nx;
    end

    // Next-state decode; a '$' restart outranks the error it raises.
    always_comb begin
        w_state_nx = r_state;
        if (w_restart) begin
            w_state_nx = ST_BODY;
        end else if (w_err) begin
            w_state_nx = ST_IDLE;
        end else begin
            case (r_state)
                ST_BODY:    if (rxValid && rxByte == ASCII_STAR) w_state_nx = ST_CSUM_HI;
                ST_CSUM_HI: if (rxValid) w_state_nx = ST_CSUM_LO;
                ST_CSUM_LO: if (rxValid) w_state_nx = ST_WAIT_CR;
                ST_WAIT_CR: if (rxValid) w_state_nx = ST_WAIT_LF;
                ST_WAIT_LF: if (rxValid) w_state_nx = w_launch ? ST_REPLAY : ST_IDLE;
                ST_REPLAY:  if (r_out_vld && r_out_end && frameReady) w_state_nx = ST_IDLE;
                default:    w_state_nx = r_state;
            endcase
        end
    end

    // Per-byte decisions: buffer writes, restart, error reason, verified launch.
    always_comb begin
        w_wr_en    = 1'b0;
        w_wr_addr  = r_len[6:0];
        w_restart  = 1'b0;
        w_err      = 1'b0;
        w_err_code = ERR_FORMAT;
        w_ok       = 1'b0;
        w_launch   = 1'b0;
        if (r_state == ST_IDLE) begin
            if (rxValid && w_is_dollar) begin
                w_restart = 1'b1;
                w_wr_en   = 1'b1;
                w_wr_addr = 7'd0;
            end
        end else if (w_framing) begin
            if (rxValid) begin
                if (w_is_dollar) begin
                    w_err     = 1'b1;
                    w_restart = 1'b1;
                    w_wr_en   = 1'b1;
                    w_wr_addr = 7'd0;
                end else if (w_len_nx > LEN_MAX) begin
                    w_err      = 1'b1;
                    w_err_code = ERR_OVERFLOW;
                end else begin
                    case (r_state)
                        ST_BODY:    w_wr_en = (rxByte != ASCII_STAR);
                        ST_CSUM_HI,
                        ST_CSUM_LO: w_err = !is_hex(rxByte);
                        ST_WAIT_CR: w_err = (rxByte != ASCII_CR);
                        ST_WAIT_LF: begin
                            if (rxByte != ASCII_LF) begin
                                w_err = 1'b1;
                            end else if (r_xor != r_csum) begin
                                w_err      = 1'b1;
                                w_err_code = ERR_CHECKSUM;
                            end else if (w_gga_ok) begin
                                w_ok     = 1'b1;
                                w_launch = 1'b1;
                            end
                        end
                        default: w_err = 1'b0;
                    endcase
                end
            end else if (r_tmo == '0) begin
                w_err      = 1'b1;
                w_err_code = ERR_TIMEOUT;
            end
        end
    end

    // The launch cycle reads address 0 so the first byte is ready one cycle later.
    assign w_adv     = !r_out_vld || frameReady;
    assign w_rd_more = (r_rd_ptr <= {1'b0, r_last});
    assign w_rd_en   = w_launch || ((r_state == ST_REPLAY) && w_adv && w_rd_more);
    assign w_rd_addr = w_launch ? 7'd0 : r_rd_ptr[6:0];

    nmea_line_buf u_buf (
        .sclk      (sclk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (rxByte),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    // Status pulses, saturating counters and the inter-byte timeout down-counter.
    always_ff @(posedge sclk) begin
        if (!rstn) begin
            r_ok       <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
            r_good     <= 16'd0;
            r_bad      <= 16'd0;
            r_tmo      <= '0;
        end else begin
            r_ok       <= w_ok;
            r_err      <= w_err;
            r_err_code <= w_err ? 2'(w_err_code) : 2'd0;
            if (w_ok && r_good != 16'hFFFF) r_good <= r_good + 16'd1;
            if (w_err && r_bad != 16'hFFFF) r_bad <= r_bad + 16'd1;
            if (rxValid)           r_tmo <= TMO_RELOAD;
            else if (r_tmo != '0)  r_tmo <= r_tmo - 1'b1;
        end
    end

    // Framing datapath: length, running XOR, received checksum, last stored index.
    always_ff @(posedge sclk) begin
        if (!rstn) begin
            r_len  <= 8'd0;
            r_xor  <= 8'd0;
            r_csum <= 8'd0;
            r_last <= 7'd0;
`ifdef NMEA_GGA_FILTER_EN
            r_gga  <= 24'd0;
`endif
        end else if (w_restart) begin
            r_len <= 8'd1;
            r_xor <= 8'd0;
`ifdef NMEA_GGA_FILTER_EN
            r_gga <= 24'd0;
`endif
        end else if (rxValid && w_framing && !w_err) begin
            r_len <= w_len_nx;
            case (r_state)
                ST_BODY: begin
                    if (rxByte == ASCII_STAR) begin
                        r_last <= r_len[6:0] - 7'd1;
                    end else begin
                        r_xor <= r_xor ^ rxByte;
`ifdef NMEA_GGA_FILTER_EN
                        if (r_len == 8'd3) r_gga[23:16] <= rxByte;
                        if (r_len == 8'd4) r_gga[15:8]  <= rxByte;
                        if (r_len == 8'd5) r_gga[7:0]   <= rxByte;
`endif
                    end
                end
                ST_CSUM_HI: r_csum[7:4] <= hex_val(rxByte);
                ST_CSUM_LO: r_csum[3:0] <= hex_val(rxByte);
                default:    r_csum <= r_csum;
            endcase
        end
    end

    // Replay pipe: RAM read register as prefetch stage, then the output register.
    always_ff @(posedge sclk) begin
        if (!rstn) begin
            r_rd_ptr    <= 8'd0;
            r_pf_vld    <= 1'b0;
            r_pf_start  <= 1'b0;
            r_pf_end    <= 1'b0;
            r_out_vld   <= 1'b0;
            r_out_start <= 1'b0;
            r_out_end   <= 1'b0;
            r_out_byte  <= 8'd0;
        end else if (w_launch) begin
            r_rd_ptr   <= 8'd1;
            r_pf_vld   <= 1'b1;
            r_pf_start <= 1'b1;
            r_pf_end   <= (r_last == 7'd0);
        end else if (r_state == ST_REPLAY) begin
            if (w_adv) begin
                r_out_vld   <= r_pf_vld;
                r_out_start <= r_pf_start;
                r_out_end   <= r_pf_end;
                r_out_byte  <= r_pf_vld ? w_rd_data : 8'd0;
                if (w_rd_more) begin
                    r_rd_ptr   <= r_rd_ptr + 8'd1;
                    r_pf_vld   <= 1'b1;
                    r_pf_start <= 1'b0;
                    r_pf_end   <= (r_rd_ptr[6:0] == r_last);
                end else begin
                    r_pf_vld   <= 1'b0;
                    r_pf_start <= 1'b0;
                    r_pf_end   <= 1'b0;
                end
            end
        end else begin
            r_pf_vld    <= 1'b0;
            r_pf_start  <= 1'b0;
            r_pf_end    <= 1'b0;
            r_out_vld   <= 1'b0;
            r_out_start <= 1'b0;
            r_out_end   <= 1'b0;
            r_out_byte  <= 8'd0;
        end
    end

    assign frameByte  = r_out_byte;
    assign frameValid = r_out_vld;
    assign frameStart = r_out_start;
    assign frameEnd   = r_out_end;
    assign frameOk    = r_ok;
    assign frameErr   = r_err;
    assign errCode    = r_err_code;
    assign goodCount  = r_good;
    assign badCount   = r_bad;

endmodule
